bram_heater_array: RTL and testbench

Parametrised array of BRAM delay-line heater channels with a staged power-up sequencer, per-channel sticky error detection, fault injection and optional saturating error counters. It sits in the 200 MHz fabric domain under the top level, replacing a flat generate loop of fixed delay instances. The error/clear vectors connect directly to the debug VIO. Staged enable limits supply droop when many BRAMs start toggling at once.

---
 rtl/heater_pkg.sv | 51 +++++
 rtl/heater_channel.sv | 99 +++++++++
 rtl/bram_heater_array.sv | 111 +++++++++++
 tb/tb_bram_heater_array.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/heater_pkg.sv
// Shared types and LFSR helpers for the BRAM heater array.
// Used by heater_channel and bram_heater_array.
package heater_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        RUN  = 2'd2
    } seq_state_t;

    localparam logic [31:0] HEATER_DEFAULT_SEED = 32'hACE1_2468;

    // Galois right-shift feedback mask for a WIDTH-bit LFSR.
    // Tap positions are 1-based; zero marks an unused tap.
    function automatic logic [71:0] lfsr_taps(input int w);
        logic [71:0] m;
        int t1;
        int t2;
        int t3;
        m  = '0;
        t1 = w - 1;
        t2 = 0;
        t3 = 0;
        case (w)
            8:  begin t1 = 6;  t2 = 5;  t3 = 4;  end
            16: begin t1 = 15; t2 = 13; t3 = 4;  end
            24: begin t1 = 23; t2 = 22; t3 = 17; end
            32: begin t1 = 22; t2 = 2;  t3 = 1;  end
            36: begin t1 = 25; t2 = 0;  t3 = 0;  end
            48: begin t1 = 47; t2 = 21; t3 = 20; end
            64: begin t1 = 63; t2 = 61; t3 = 60; end
            72: begin t1 = 66; t2 = 25; t3 = 19; end
            default: ;
        endcase
        m[w-1] = 1'b1;
        if (t1 > 0) m[t1-1] = 1'b1;
        if (t2 > 0) m[t2-1] = 1'b1;
        if (t3 > 0) m[t3-1] = 1'b1;
        return m;
    endfunction

    // Per-channel seed, truncated to the word width; an all-zero seed would lock up.
    function automatic logic [71:0] lfsr_seed(input logic [31:0] seed, input int ch, input int w);
        logic [71:0] s;
        s = {40'd0, seed ^ 32'(ch)};
        if (w < 72) s = s & ((72'd1 << w) - 72'd1);
        if (s == '0) s = 72'd1;
        return s;
    endfunction

endpackage

// File: rtl/heater_channel.sv
// One heater channel: read-first BRAM delay line fed by an LFSR, checked against a second LFSR.
// Optional saturating mismatch counter when HEATER_ERR_CNT_EN is defined.
module heater_channel
    import heater_pkg::*;
#(
    parameter int          DEPTH = 1024,
    parameter int          WIDTH = 32,
    parameter int          CNT_W = 16,
    parameter logic [31:0] SEED  = HEATER_DEFAULT_SEED,
    parameter int          CH    = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             active_i,
    input  logic             inject_i,
    input  logic             err_clear_i,
    output logic             error_o
`ifdef HEATER_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] err_count_o
`endif
);

    localparam int               AW        = $clog2(DEPTH);
    localparam logic [71:0]      TAPS_FULL = lfsr_taps(WIDTH);
    localparam logic [71:0]      SEED_FULL = lfsr_seed(SEED, CH, WIDTH);
    localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_W    = SEED_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr_q;
    logic             fill_q;
    logic             rd_vld_q;
    logic [WIDTH-1:0] pat_q;
    logic [WIDTH-1:0] chk_q;
    logic [WIDTH-1:0] rd_q;
    logic [WIDTH-1:0] wr_data;
    logic             mismatch;
    logic             error_q;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction

    assign wr_data = pat_q ^ {{(WIDTH-1){1'b0}}, inject_i};

    // Read-first: rd_q captures the word written DEPTH cycles earlier.
    always_ff @(posedge clk) begin
        if (active_i) begin
            mem[ptr_q] <= wr_data;
            rd_q       <= mem[ptr_q];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q    <= '0;
            fill_q   <= 1'b0;
            rd_vld_q <= 1'b0;
            pat_q    <= SEED_W;
            chk_q    <= SEED_W;
        end else if (!active_i) begin
            ptr_q    <= '0;
            fill_q   <= 1'b0;
            rd_vld_q <= 1'b0;
            pat_q    <= SEED_W;
            chk_q    <= SEED_W;
        end else begin
            ptr_q    <= ptr_q + AW'(1);
            if (ptr_q == AW'(DEPTH - 1)) fill_q <= 1'b1;
            rd_vld_q <= fill_q;
            pat_q    <= lfsr_step(pat_q);
            if (rd_vld_q) chk_q <= lfsr_step(chk_q);
        end
    end

    assign mismatch = active_i && rd_vld_q && (rd_q != chk_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         error_q <= 1'b0;
        else if (err_clear_i) error_q <= 1'b0;
        else if (mismatch)    error_q <= 1'b1;
    end

    assign error_o = error_q;

`ifdef HEATER_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                      cnt_q <= '0;
        else if (err_clear_i)              cnt_q <= '0;
        else if (mismatch && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign err_count_o = cnt_q;
`endif

endmodule

// File: rtl/bram_heater_array.sv
// Array of BRAM heater channels behind a staged power-up sequencer (IDLE/RAMP/RUN).
// Define HEATER_ERR_CNT_EN to add per-channel saturating error counters and the err_count port.
module bram_heater_array
    import heater_pkg::*;
#(
    parameter int          N_CH      = 32,
    parameter int          DEPTH     = 1024,
    parameter int          WIDTH     = 32,
    parameter int          RAMP_STEP = 256,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] SEED      = HEATER_DEFAULT_SEED
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    run,
    input  logic [N_CH-1:0]         ch_mask,
    input  logic [N_CH-1:0]         err_clear,
    input  logic [N_CH-1:0]         inject,
    output logic [N_CH-1:0]         active,
    output logic [N_CH-1:0]         error,
    output logic [1:0]              state
`ifdef HEATER_ERR_CNT_EN
    ,
    output logic [N_CH*CNT_W-1:0]   err_count
`endif
);

    localparam int              TW        = (RAMP_STEP > 1) ? $clog2(RAMP_STEP) : 1;
    localparam logic [TW-1:0]   STEP_LAST = TW'(RAMP_STEP - 1);
    localparam logic [N_CH-1:0] ONE_N     = N_CH'(1);

    seq_state_t      state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [N_CH-1:0] active_q, active_d;
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] first_pending;

    // Masked channels still waiting for their turn; isolate the lowest one.
    assign pending       = ch_mask & ~active_q;
    assign first_pending = pending & (~pending + ONE_N);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        active_d = active_q & ch_mask;
        if (!run) begin
            state_d  = IDLE;
            timer_d  = '0;
            active_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = RAMP;
                    timer_d = '0;
                end
                RAMP: begin
                    if (pending == '0) begin
                        state_d = RUN;
                        timer_d = '0;
                    end else if (timer_q == STEP_LAST) begin
                        timer_d  = '0;
                        active_d = active_d | first_pending;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                RUN: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            active_q <= active_d;
        end
    end

    assign active = active_q;
    assign state  = state_q;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            heater_channel #(
                .DEPTH (DEPTH),
                .WIDTH (WIDTH),
                .CNT_W (CNT_W),
                .SEED  (SEED),
                .CH    (gi)
            ) u_ch (
                .clk         (clk),
                .reset_n     (reset_n),
                .active_i    (active_q[gi]),
                .inject_i    (inject[gi]),
                .err_clear_i (err_clear[gi]),
                .error_o     (error[gi])
`ifdef HEATER_ERR_CNT_EN
                ,
                .err_count_o (err_count[gi*CNT_W +: CNT_W])
`endif
            );
        end
    endgenerate

endmodule

// File: tb/tb_bram_heater_array.sv
// Self-checking bench for bram_heater_array: timing-level model plus directed literal checks.
module tb_bram_heater_array;

    localparam int N  = 4;
    localparam int D  = 16;
    localparam int W  = 16;
    localparam int RS = 8;
    localparam int CW = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         run = 1'b0;
    logic [N-1:0] ch_mask = '0;
    logic [N-1:0] err_clear = '0;
    logic [N-1:0] inject = '0;
    logic [N-1:0] active;
    logic [N-1:0] error;
    logic [1:0]   state;
`ifdef HEATER_ERR_CNT_EN
    logic [N*CW-1:0] err_count;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bram_heater_array #(
        .N_CH      (N),
        .DEPTH     (D),
        .WIDTH     (W),
        .RAMP_STEP (RS),
        .CNT_W     (CW),
        .SEED      (32'hACE1_2468)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .ch_mask   (ch_mask),
        .err_clear (err_clear),
        .inject    (inject),
        .active    (active),
        .error     (error),
        .state     (state)
`ifdef HEATER_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int ch;
        int due;
        int streak;
    } ev_t;

    ev_t          evq[$];
    int           m_phase = 0;
    int           m_ramp_t = 0;
    logic [N-1:0] m_act = '0;
    logic [N-1:0] m_err = '0;
    int           m_cnt[N];
    int           m_streak[N];

    always @(negedge clk) begin
        logic [N-1:0]    nact;
        logic [N-1:0]    mis;
        logic [N*CW-1:0] cvec;
        int              rank;
        if (!reset_n) begin
            m_phase  = 0;
            m_ramp_t = 0;
            m_act    = '0;
            m_err    = '0;
            for (int i = 0; i < N; i++) begin
                m_cnt[i]    = 0;
                m_streak[i] = -1;
            end
            evq.delete();
        end else begin
            cvec = '0;
            for (int i = 0; i < N; i++) cvec[i*CW +: CW] = m_cnt[i][CW-1:0];
            check("model_state", {30'd0, state}, m_phase);
            check("model_active", {28'd0, active}, {28'd0, m_act});
            check("model_error", {28'd0, error}, {28'd0, m_err});
`ifdef HEATER_ERR_CNT_EN
            check("model_count", {24'd0, err_count}, {24'd0, cvec});
`endif
            // A corrupted word is compared DEPTH+1 cycles after it was written,
            // provided the channel stayed enabled without interruption.
            mis = '0;
            for (int k = evq.size() - 1; k >= 0; k--) begin
                if (evq[k].due == cyc) begin
                    if (m_act[evq[k].ch] && m_streak[evq[k].ch] == evq[k].streak)
                        mis[evq[k].ch] = 1'b1;
                    evq.delete(k);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (inject[i] && m_act[i])
                    evq.push_back('{ch: i, due: cyc + D + 1, streak: m_streak[i]});
                if (err_clear[i]) begin
                    m_err[i] = 1'b0;
                    m_cnt[i] = 0;
                end else if (mis[i]) begin
                    m_err[i] = 1'b1;
                    if (m_cnt[i] < CNT_MAX) m_cnt[i]++;
                end
            end
            nact = m_act & ch_mask;
            if (!run) begin
                m_phase = 0;
                nact    = '0;
            end else if (m_phase == 0) begin
                m_phase  = 1;
                m_ramp_t = 0;
            end else if (m_phase == 1) begin
                if ((ch_mask & ~m_act) == '0) begin
                    m_phase = 2;
                end else begin
                    // The k-th set mask bit turns on (k+1)*RS cycles after RAMP entry.
                    rank = 0;
                    for (int i = 0; i < N; i++) begin
                        if (ch_mask[i]) begin
                            if (m_ramp_t + 1 == (rank + 1) * RS) nact[i] = 1'b1;
                            rank++;
                        end
                    end
                    m_ramp_t++;
                end
            end
            for (int i = 0; i < N; i++)
                if (nact[i] && !m_act[i]) m_streak[i] = cyc + 1;
            m_act = nact;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tick(3);
        check("reset_state", {30'd0, state}, 32'd0);
        check("reset_active", {28'd0, active}, 32'd0);
        check("reset_error", {28'd0, error}, 32'd0);
        reset_n = 1'b1;
        tick(2);
        check("idle_without_run", {30'd0, state}, 32'd0);

        // Basic ramp, mask 1011
        ch_mask = 4'b1011;
        run     = 1'b1;
        tick(8);
        check("ramp_before_first", {28'd0, active}, 32'h0);
        check("ramp_state", {30'd0, state}, 32'd1);
        tick(1);
        check("ramp_ch0", {28'd0, active}, 32'h1);
        tick(8);
        check("ramp_ch1", {28'd0, active}, 32'h3);
        tick(8);
        check("ramp_ch3", {28'd0, active}, 32'hB);
        check("ramp_last_state", {30'd0, state}, 32'd1);
        tick(1);
        check("run_state", {30'd0, state}, 32'd2);
        tick(1000);
        check("no_errors_1000", {28'd0, error}, 32'h0);

        // Single fault on channel 1
        inject = 4'b0010;
        tick(1);
        inject = '0;
        tick(16);
        check("fault_not_yet", {28'd0, error}, 32'h0);
        tick(1);
        check("fault_seen", {28'd0, error}, 32'h2);
`ifdef HEATER_ERR_CNT_EN
        check("fault_count", {24'd0, err_count}, 32'h04);
`endif
        tick(50);
        check("fault_sticky", {28'd0, error}, 32'h2);

        // Clear wins over a simultaneous mismatch
        err_clear = 4'b0010;
        tick(1);
        check("clear_applied", {28'd0, error}, 32'h0);
        inject = 4'b0010;
        tick(1);
        inject = '0;
        tick(17);
        check("clear_blocks_fault", {28'd0, error}, 32'h0);
        tick(10);
        err_clear = '0;
        tick(40);
        check("after_clear_release", {28'd0, error}, 32'h0);

        // Injection into an inactive channel has no effect
        inject = 4'b0100;
        tick(1);
        inject = '0;
        tick(30);
        check("inactive_inject", {28'd0, error}, 32'h0);

        // Mask changes in RUN
        ch_mask = 4'b1001;
        tick(1);
        check("mask_drop", {28'd0, active}, 32'h9);
        ch_mask = 4'b1011;
        tick(5);
        check("mask_set_in_run", {28'd0, active}, 32'h9);
        check("mask_state_run", {30'd0, state}, 32'd2);

        // Stop in RUN, then stop mid-RAMP, then restart
        run = 1'b0;
        tick(1);
        check("stop_active", {28'd0, active}, 32'h0);
        check("stop_state", {30'd0, state}, 32'd0);
        run = 1'b1;
        tick(12);
        check("midramp_active", {28'd0, active}, 32'h1);
        check("midramp_state", {30'd0, state}, 32'd1);
        run = 1'b0;
        tick(1);
        check("midramp_stop_active", {28'd0, active}, 32'h0);
        check("midramp_stop_state", {30'd0, state}, 32'd0);
        run = 1'b1;
        tick(200);
        check("restart_active", {28'd0, active}, 32'hB);
        check("restart_state", {30'd0, state}, 32'd2);
        check("restart_no_errors", {28'd0, error}, 32'h0);

        // Saturation
        inject = 4'b0010;
        tick(20);
        inject = '0;
        tick(40);
        check("sat_error", {28'd0, error}, 32'h2);
`ifdef HEATER_ERR_CNT_EN
        check("sat_count", {24'd0, err_count}, 32'h0C);
`endif

        // Asynchronous reset during RUN
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_active", {28'd0, active}, 32'h0);
        check("areset_state", {30'd0, state}, 32'd0);
        check("areset_error", {28'd0, error}, 32'h0);
`ifdef HEATER_ERR_CNT_EN
        check("areset_count", {24'd0, err_count}, 32'h0);
`endif
        tick(3);
        run     = 1'b0;
        reset_n = 1'b1;
        tick(5);
        check("post_reset_idle", {30'd0, state}, 32'd0);
        run = 1'b1;
        tick(1);
        check("post_reset_ramp", {30'd0, state}, 32'd1);
        tick(8);
        check("post_reset_ch0", {28'd0, active}, 32'h1);
        tick(100);
        run = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
